// File: rtl/snn_output_store.sv
// rtl/snn_output_store.sv - output-layer spike accumulator, result store and argmax
//
// Counts spikes per output neuron, sweeps the counts into a result memory
// one entry per output_cntr_en cycle, and optionally tracks the winner.
// Optional feature macro: SNN_OUTPUT_ARGMAX_EN (winner tracking; when undefined
// the winner outputs are tied to 0).
//
// Ports:
//   clk             - clock, rising edge
//   rst             - synchronous active-low reset
//   clear_counts    - zero all accumulators (one-cycle pulse)
//   spike_valid     - spike_in qualifier, one pulse per timestep
//   spike_in        - output-layer spike vector, bit i = neuron i
//   output_cntr_rst - restart the store sweep (index, running max, winner_valid)
//   output_cntr_en  - store one result and advance the index
//   outputs_done    - combinational, high on the cycle writing the last entry
//   rd_addr         - result read address
//   rd_data         - registered read data (0 for out-of-range addresses)
//   winner_idx      - index of maximum stored count
//   winner_count    - maximum stored count
//   winner_valid    - winner outputs reflect a completed sweep

module snn_output_store #(
  parameter int NUM_OUTPUTS = 10,
  parameter int COUNT_WIDTH = 8,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_counts,
  input  logic                   spike_valid,
  input  logic [NUM_OUTPUTS-1:0] spike_in,
  input  logic                   output_cntr_rst,
  input  logic                   output_cntr_en,
  output logic                   outputs_done,
  input  logic [IDX_WIDTH-1:0]   rd_addr,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic [IDX_WIDTH-1:0]   winner_idx,
  output logic [COUNT_WIDTH-1:0] winner_count,
  output logic                   winner_valid
);

  localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [IDX_WIDTH:0]     NUM_EXT   = (IDX_WIDTH + 1)'(NUM_OUTPUTS);
  localparam logic [COUNT_WIDTH-1:0] SAT_COUNT = '1;

  logic [COUNT_WIDTH-1:0] acc_q [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0] res_q [NUM_OUTPUTS];
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [IDX_WIDTH-1:0]   idx_d;
  logic [COUNT_WIDTH-1:0] rd_data_q;
  logic                   at_last;
  logic                   store_we;
  logic [COUNT_WIDTH-1:0] store_val;

  // output_cntr_rst pre-empts a write in the same cycle; reset also blocks it
  assign at_last      = (idx_q == LAST_IDX);
  assign store_we     = rst & output_cntr_en & ~output_cntr_rst;
  assign outputs_done = store_we & at_last;
  assign store_val    = acc_q[idx_q];
  assign rd_data      = rd_data_q;

  always_comb begin
    idx_d = idx_q;
    if (store_we) begin
      idx_d = at_last ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
      idx_q     <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (clear_counts) begin
          // a spike coinciding with the clear counts as the first spike
          acc_q[i] <= COUNT_WIDTH'(spike_valid & spike_in[i]);
        end else if (spike_valid && spike_in[i] && (acc_q[i] != SAT_COUNT)) begin
          acc_q[i] <= acc_q[i] + 1'b1;
        end
      end

      // store_val is the pre-update accumulator value
      if (store_we) begin
        res_q[idx_q] <= store_val;
      end
      idx_q <= output_cntr_rst ? '0 : idx_d;

      // non-blocking res_q update means a colliding read returns the old value
      if ({1'b0, rd_addr} < NUM_EXT) begin
        rd_data_q <= res_q[rd_addr];
      end else begin
        rd_data_q <= '0;
      end
    end
  end

`ifdef SNN_OUTPUT_ARGMAX_EN
  logic [COUNT_WIDTH-1:0] max_run_q;
  logic [IDX_WIDTH-1:0]   max_idx_q;
  logic [COUNT_WIDTH-1:0] max_run_d;
  logic [IDX_WIDTH-1:0]   max_idx_d;
  logic [COUNT_WIDTH-1:0] win_count_q;
  logic [IDX_WIDTH-1:0]   win_idx_q;
  logic                   win_valid_q;
  logic                   new_max;

  // strict compare keeps the lowest index on ties
  assign new_max   = (store_val > max_run_q);
  assign max_run_d = new_max ? store_val : max_run_q;
  assign max_idx_d = new_max ? idx_q : max_idx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_run_q   <= '0;
      max_idx_q   <= '0;
      win_count_q <= '0;
      win_idx_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      if (output_cntr_rst) begin
        max_run_q <= '0;
        max_idx_q <= '0;
      end else if (store_we) begin
        max_run_q <= max_run_d;
        max_idx_q <= max_idx_d;
        if (at_last) begin
          win_count_q <= max_run_d;
          win_idx_q   <= max_idx_d;
        end
      end

      if (output_cntr_rst || clear_counts) begin
        win_valid_q <= 1'b0;
      end else if (outputs_done) begin
        win_valid_q <= 1'b1;
      end
    end
  end

  assign winner_idx   = win_idx_q;
  assign winner_count = win_count_q;
  assign winner_valid = win_valid_q;
`else
  assign winner_idx   = '0;
  assign winner_count = '0;
  assign winner_valid = 1'b0;
`endif

endmodule

// File: tb/tb_snn_output_store.sv
// tb/tb_snn_output_store.sv - directed self-checking bench for snn_output_store

module tb_snn_output_store;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_counts;
  logic       spike_valid;
  logic [9:0] spike_in;
  logic       output_cntr_rst;
  logic       output_cntr_en;
  logic       outputs_done;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] winner_idx;
  logic [7:0] winner_count;
  logic       winner_valid;

  int passed = 0;
  int total  = 0;

  snn_output_store #(
    .NUM_OUTPUTS(10),
    .COUNT_WIDTH(8),
    .IDX_WIDTH  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear_counts   (clear_counts),
    .spike_valid    (spike_valid),
    .spike_in       (spike_in),
    .output_cntr_rst(output_cntr_rst),
    .output_cntr_en (output_cntr_en),
    .outputs_done   (outputs_done),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .winner_idx     (winner_idx),
    .winner_count   (winner_count),
    .winner_valid   (winner_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    rd_addr = a;
    tick();
    chk(tag, rd_data, exp);
  endtask

  task automatic pulse(input logic [9:0] v, input int n);
    spike_in    = v;
    spike_valid = 1'b1;
    repeat (n) tick();
    spike_valid = 1'b0;
    spike_in    = '0;
  endtask

  task automatic cntr_rst();
    output_cntr_rst = 1'b1;
    tick();
    output_cntr_rst = 1'b0;
  endtask

  task automatic en_cycle(input logic exp_done, input string tag);
    output_cntr_en = 1'b1;
    #1;
    chk(tag, outputs_done, exp_done);
    tick();
    output_cntr_en = 1'b0;
  endtask

  task automatic chk_win(input int widx, input int wcnt, input int wval, input string tag);
`ifdef SNN_OUTPUT_ARGMAX_EN
    chk({tag, "_idx"}, winner_idx, widx);
    chk({tag, "_cnt"}, winner_count, wcnt);
    chk({tag, "_val"}, winner_valid, wval);
`else
    chk({tag, "_idx"}, winner_idx, 0);
    chk({tag, "_cnt"}, winner_count, 0);
    chk({tag, "_val"}, winner_valid, 0);
`endif
  endtask

  initial begin
    int exp_g [10];
    exp_g = '{0, 2, 2, 0, 0, 0, 3, 0, 0, 2};

    rst             = 1'b0;
    clear_counts    = 1'b0;
    spike_valid     = 1'b0;
    spike_in        = '0;
    output_cntr_rst = 1'b0;
    output_cntr_en  = 1'b0;
    rd_addr         = '0;

    // reset
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", outputs_done, 0);
    chk_win(0, 0, 0, "rst_win");
    for (int a = 0; a < 10; a++) rd(a[3:0], 0, "rst_read");

    // accumulate and sweep
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    pulse(10'b00_0000_1001, 5);
    cntr_rst();
    for (int k = 0; k < 10; k++) en_cycle(k == 9, "sweep1_done");
    #1;
    chk("sweep1_done_after", outputs_done, 0);
    chk_win(0, 5, 1, "sweep1_win");
    for (int a = 0; a < 10; a++) rd(a[3:0], (a == 0 || a == 3) ? 5 : 0, "sweep1_read");

    // out-of-range reads
    rd(4'd12, 0, "rd_addr12");
    rd(4'd15, 0, "rd_addr15");

    // saturation
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    pulse(10'b00_1000_0000, 300);
    cntr_rst();
    for (int k = 0; k < 10; k++) en_cycle(k == 9, "sat_done");
    rd(4'd7, 255, "sat_res7");
    rd(4'd0, 0, "sat_res0");
    chk_win(7, 255, 1, "sat_win");

    // clear with coincident spike, then cntr_rst with cntr_en
    clear_counts = 1'b1;
    spike_valid  = 1'b1;
    spike_in     = 10'b00_0000_0100;
    tick();
    clear_counts = 1'b0;
    spike_valid  = 1'b0;
    spike_in     = '0;
    cntr_rst();
    for (int k = 0; k < 3; k++) en_cycle(1'b0, "part_done");
    pulse(10'b00_0000_1000, 1);
    output_cntr_rst = 1'b1;
    output_cntr_en  = 1'b1;
    #1;
    chk("rst_en_done", outputs_done, 0);
    tick();
    output_cntr_rst = 1'b0;
    output_cntr_en  = 1'b0;
    rd(4'd3, 0, "rst_en_nowrite");
    rd(4'd2, 1, "clear_spike_res2");
    for (int k = 0; k < 10; k++) en_cycle(k == 9, "after_rst_en_done");
    rd(4'd3, 1, "after_rst_en_res3");
    rd(4'd7, 0, "after_rst_en_res7");
    chk_win(2, 1, 1, "tie_win");

    // gapped sweep with spike during store and read/write collision
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    pulse(10'b10_0100_0110, 2);
    pulse(10'b00_0100_0000, 1);
    cntr_rst();
    chk("gap_valid_cleared", winner_valid, 0);
    for (int j = 0; j < 20; j++) begin
      output_cntr_en = (j % 2 == 0);
      if (j == 0) begin
        spike_valid = 1'b1;
        spike_in    = 10'b00_0000_0001;
      end
      if (j == 18) rd_addr = 4'd9;
      #1;
      chk("gap_done", outputs_done, j == 18);
      tick();
      spike_valid = 1'b0;
      spike_in    = '0;
      if (j == 18) chk("collide_old", rd_data, 0);
      if (j == 19) chk("collide_new", rd_data, 2);
    end
    output_cntr_en = 1'b0;
    chk_win(6, 3, 1, "gap_win");
    for (int a = 0; a < 10; a++) rd(a[3:0], exp_g[a], "gap_read");
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    chk("clear_drops_valid", winner_valid, 0);

    // reset mid-sweep
    cntr_rst();
    for (int k = 0; k < 5; k++) en_cycle(1'b0, "mid_done");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_win(0, 0, 0, "midrst_win");
    rd(4'd6, 0, "midrst_res6");
    for (int k = 0; k < 10; k++) en_cycle(k == 9, "midrst_done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/snn_output_store.md
# snn_output_store

Output-layer spike accumulator and result store for the SNN core. While the network runs, it counts each output neuron's spikes per timestep. It then sweeps the counts into a readable result memory under the `output_cntr_rst` / `output_cntr_en` strobes from `snn_core_controller`, and returns `outputs_done` to that controller. Optional winner (argmax) logic produces the classification result.

## Interface
- `NUM_OUTPUTS`, 10: number of output neurons, ≥2.
- `COUNT_WIDTH`, 8: width of each spike counter and stored result.
- `IDX_WIDTH`, 4: index width; must satisfy 2^IDX_WIDTH ≥ NUM_OUTPUTS.
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `clear_counts` in 1: one-cycle pulse that zeroes all accumulators (driven at `network_start`).
- `spike_valid` in 1: one pulse per network timestep; `spike_in` is sampled only when this is high.
- `spike_in` in NUM_OUTPUTS: output-layer spike vector; bit i is neuron i.
- `output_cntr_rst` in 1: resets store index, running max and `winner_valid`.
- `output_cntr_en` in 1: each high cycle stores one result and advances the index.
- `outputs_done` out 1: combinational; high when `output_cntr_en` = 1 and index = NUM_OUTPUTS-1.
- `rd_addr` in IDX_WIDTH: result-memory read address.
- `rd_data` out COUNT_WIDTH: registered read data.
- `winner_idx` out IDX_WIDTH: index of the neuron with the maximum stored count.
- `winner_count` out COUNT_WIDTH: that neuron's count.
- `winner_valid` out 1: winner outputs reflect a completed sweep.

## Operation
- **Accumulate.** On a cycle with `spike_valid` and `spike_in[i]` both high, `acc[i]` increments. It saturates at 2^COUNT_WIDTH-1 and never wraps.
- **Clear.** `clear_counts` sets every `acc[i]` to 0. If `spike_valid` is high in the same cycle, `acc[i]` becomes `spike_in[i]`.
- **Store index `idx`.**
  - `output_cntr_rst` sets `idx` to 0. It has priority over `output_cntr_en` in the same cycle, and no write occurs.
  - Each `output_cntr_en` cycle writes `acc[idx]` (the pre-update value, even if a spike arrives that cycle) to `res[idx]`.
  - After the write, `idx` increments. From NUM_OUTPUTS-1 it wraps to 0.
- **Done.** `outputs_done` is high exactly during the cycle that writes `res[NUM_OUTPUTS-1]`. The controller leaves its store state on the following edge.
- **Read port.** `rd_data` is loaded with `res[rd_addr]` every cycle. If `rd_addr` ≥ NUM_OUTPUTS, `rd_data` is loaded with 0.
- **Write/read collision.** A read of the address being written that cycle returns the old value.
- **Winner tracking.**
  - On each store write, if `acc[idx]` > `max_run` (strict comparison), `max_run` and `max_idx` update. Ties therefore keep the lowest index.
  - `output_cntr_rst` loads `max_run` = 0 and `max_idx` = 0.
  - On the edge that writes index NUM_OUTPUTS-1, `winner_idx` and `winner_count` load the final max (including that last entry) and `winner_valid` goes to 1.
  - `winner_valid` clears on `output_cntr_rst` or `clear_counts`.

## Timing
- Reset (`rst` = 0 at an edge) sets all of the following to 0: `acc[]`, `res[]`, `idx`, `max_run`, `max_idx`, `rd_data`, `winner_idx`, `winner_count`, `winner_valid`.
- Reset mid-sweep aborts the sweep. `outputs_done` stays low until a new sweep reaches the last index.
- Spike accumulation latency: 1 cycle (count is visible on the edge after `spike_valid`).
- Sweep duration: exactly NUM_OUTPUTS `output_cntr_en` cycles. Gaps between enable cycles are allowed, and the index holds during them.
- `rd_data` latency: 1 cycle from `rd_addr`.
- `winner_*` outputs update on the edge that ends the `outputs_done` cycle.
- `outputs_done` has zero latency from `output_cntr_en`.

## Configuration
- Macro `SNN_OUTPUT_ARGMAX_EN`.
- **Defined:** winner tracking is implemented as described under Operation.
- **Undefined:** no comparator or max registers are built. `winner_idx`, `winner_count` and `winner_valid` are tied to 0. Store, read and done behaviour are unchanged.

## Test plan
- **Reset.** Hold `rst` = 0 for 3 cycles, then release. All outputs read 0, `outputs_done` = 0, and reads of addresses 0–9 return 0.
- **Accumulate and sweep.** Pulse `clear_counts`. Apply 5 `spike_valid` pulses with `spike_in` = 10'b00_0000_1001, then `output_cntr_rst`, then 10 `output_cntr_en` cycles. Expected:
  - `res[0]` = 5, `res[3]` = 5, all other entries 0.
  - `outputs_done` is high only on the 10th enable cycle.
  - With the macro defined: `winner_idx` = 0, `winner_count` = 5, `winner_valid` = 1.
- **Saturation.** 300 pulses on bit 7 with COUNT_WIDTH = 8. `res[7]` = 255.
- **Simultaneous events.**
  - `clear_counts` with `spike_valid` and bit 2 set in the same cycle: `acc[2]` = 1.
  - `output_cntr_rst` with `output_cntr_en` in the same cycle: no write, `idx` = 0.
- **Gapped sweep.** Enable pattern 1,0,1,... (10 ones). Stored values match `acc`, and `outputs_done` aligns with the 10th one.
- **Read edge cases.**
  - `rd_addr` = 12 returns `rd_data` = 0.
  - Reading the address being written returns the old value, and the new value on the next cycle.
